// File: rtl/float_to_int_arbiter.sv
// Round-robin share of one pipelined FloatToInt converter, tag pipe matched to its latency, FWFT result FIFO.
// Optional `FLOAT_TO_INT_ARB_SAT_EN: detect exponent overflow at issue and store saturated results.
module float_to_int_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int MANTISSA_SIZE        = 23,
  parameter int EXPONENT_SIZE        = 8,
  parameter int INT_SIZE             = 32,
  parameter int EXPONENT_BIAS_OFFSET = 0,
  parameter int LATENCY              = 4,
  parameter int FIFO_DEPTH           = 8,
  localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FLOAT_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FLOAT_SIZE-1:0]         conv_in,
  input  logic [INT_SIZE-1:0]           conv_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [INT_SIZE-1:0]           res_data,
  output logic [ID_W-1:0]               res_id,
  output logic                          res_sat
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int ENT_W = ID_W + 1 + INT_SIZE;
  localparam int BIAS  = (2 ** (EXPONENT_SIZE - 1)) - 1 + EXPONENT_BIAS_OFFSET;

  if (NUM_REQ < 2) begin : g_chk_req
    $error("NUM_REQ must be at least 2");
  end
  if (FIFO_DEPTH < LATENCY + 1) begin : g_chk_depth
    $error("FIFO_DEPTH must cover every in-flight conversion plus one");
  end
  if (BIAS <= 0) begin : g_chk_bias
    $error("exponent bias must be positive");
  end

  logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [LATENCY-1:0]            tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic [LATENCY-1:0]            tag_sat_q, tag_sat_d;
`ifdef FLOAT_TO_INT_ARB_SAT_EN
  logic [LATENCY-1:0]            tag_neg_q, tag_neg_d;
`endif
  logic [ENT_W-1:0]              mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]              mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              fifo_cnt_q, fifo_cnt_d, inflight_q, inflight_d;

  logic            issue_ok, gnt_vld, issue_sat, push, pop;
  logic [ID_W-1:0] gnt_id;
  logic [INT_SIZE-1:0] push_data;
  logic [ENT_W-1:0]    head;

  // Credit uses registered counts only, so a pop in this cycle frees nothing until next cycle.
  assign issue_ok = (SUM_W'(fifo_cnt_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (issue_ok) begin
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        idx = (int'(rr_ptr_q) + off) % NUM_REQ;
        if (req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    conv_in   = '0;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
      conv_in           = req_data[gnt_id*FLOAT_SIZE +: FLOAT_SIZE];
      rr_ptr_d          = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_comb begin
    issue_sat = 1'b0;
`ifdef FLOAT_TO_INT_ARB_SAT_EN
    begin
      int unb;
      unb       = int'(conv_in[FLOAT_SIZE-2 -: EXPONENT_SIZE]) - BIAS;
      issue_sat = gnt_vld && (unb >= INT_SIZE - 1);
    end
`endif
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_sat_d    = '0;
    tag_vld_d[0] = gnt_vld;
    tag_id_d[0]  = gnt_id;
    tag_sat_d[0] = issue_sat;
`ifdef FLOAT_TO_INT_ARB_SAT_EN
    tag_neg_d    = '0;
    tag_neg_d[0] = conv_in[FLOAT_SIZE-1];
`endif
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
      tag_sat_d[i] = tag_sat_q[i-1];
`ifdef FLOAT_TO_INT_ARB_SAT_EN
      tag_neg_d[i] = tag_neg_q[i-1];
`endif
    end
  end

  assign push = tag_vld_q[LATENCY-1];
  assign head = mem_q[rd_ptr_q];
  assign res_valid = (fifo_cnt_q != '0);
  assign pop  = res_valid && res_ready;

  always_comb begin
    push_data = conv_out;
`ifdef FLOAT_TO_INT_ARB_SAT_EN
    if (tag_sat_q[LATENCY-1]) begin
      push_data = tag_neg_q[LATENCY-1] ? {1'b1, {(INT_SIZE-1){1'b0}}} : {1'b0, {(INT_SIZE-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d = inflight_q + CNT_W'(gnt_vld) - CNT_W'(push);
    if (push) begin
      mem_d[wr_ptr_q] = {tag_id_q[LATENCY-1], tag_sat_q[LATENCY-1], push_data};
      wr_ptr_d        = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  assign res_data = res_valid ? head[INT_SIZE-1:0]    : '0;
  assign res_sat  = res_valid & head[INT_SIZE];
  assign res_id   = res_valid ? head[ENT_W-1 -: ID_W] : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      tag_sat_q  <= '0;
`ifdef FLOAT_TO_INT_ARB_SAT_EN
      tag_neg_q  <= '0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      tag_sat_q  <= tag_sat_d;
`ifdef FLOAT_TO_INT_ARB_SAT_EN
      tag_neg_q  <= tag_neg_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset: the read side is gated by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  push_while_full_a: assert property (@(posedge clk) disable iff (!resetn)
    !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule
